spcore_ctrl: RTL and testbench

SPCORE_CTRL -- requirements
Module: spcore_ctrl

---
 rtl/spcore_ctrl_pkg.sv | 39 +++
 rtl/spcore_ctrl.sv | 116 +++++++++++
 tb/tb_spcore_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spcore_ctrl_pkg.sv
// Shared constants for the spcore sequencer: opcodes, FSM states, register-write
// mux selects and ALU control codes.
package spcore_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_IMM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BRP   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;

  localparam logic [1:0] MUXD_FROM_I   = 2'd0;
  localparam logic [1:0] MUXD_FROM_ALU = 2'd1;
  localparam logic [1:0] MUXD_FROM_MEM = 2'd2;

  // ALU opcodes 0x8-0xF map straight onto these codes via the low three op bits
  localparam logic [3:0] ALUC_ADD = 4'd0;
  localparam logic [3:0] ALUC_SUB = 4'd1;
  localparam logic [3:0] ALUC_AND = 4'd2;
  localparam logic [3:0] ALUC_OR  = 4'd3;
  localparam logic [3:0] ALUC_XOR = 4'd4;
  localparam logic [3:0] ALUC_NOT = 4'd5;
  localparam logic [3:0] ALUC_SHL = 4'd6;
  localparam logic [3:0] ALUC_SHR = 4'd7;

  function automatic logic [3:0] alu_ctrl(input logic [3:0] op);
    return {1'b0, op[2:0]};
  endfunction

endpackage

// File: rtl/spcore_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer that drives the spcore datapath
// strobes from a 16-bit instruction stream.
// imem handshake: imem_req stays high in FETCH/IMM until a cycle with imem_valid=1;
// that cycle's imem_data is the accepted word, and imem_valid is ignored otherwise.
module spcore_ctrl
  import spcore_ctrl_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            imem_valid,
  input  logic            P,
  output logic [3:0]      x,
  output logic [3:0]      y,
  output logic [3:0]      z,
  output logic [15:0]     I,
  output logic [3:0]      aluc,
  output logic [1:0]      s2,
  output logic            reg_we,
  output logic            mem_we,
  output logic            en,
  output logic [2:0]      state_dbg
);

  localparam logic [PC_W-1:0] START = PC_W'(START_PC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [15:0]     imm_q;

  logic [3:0] op;
  logic       is_loadi, is_load, is_store, is_brp, is_halt, is_alu, active;

  assign op       = ir_q[15:12];
  assign is_loadi = (op == OP_LOADI);
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_brp   = (op == OP_BRP);
  assign is_halt  = (op == OP_HALT);
  assign is_alu   = op[3];
  assign active   = (state_q == ST_DECODE) || (state_q == ST_IMM) ||
                    (state_q == ST_MEM)    || (state_q == ST_EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        pc_q <= START;
      end else if (state_q == ST_FETCH && imem_valid) begin
        ir_q <= imem_data;
        pc_q <= pc_q + 1'b1;
      end else if (state_q == ST_IMM && imem_valid) begin
        imm_q <= imem_data;
        pc_q  <= pc_q + 1'b1;
      end else if (state_q == ST_EXEC && is_brp && P) begin
        // pc already points past the branch word; offset {y,z} is signed
        pc_q <= pc_q + PC_W'($signed(ir_q[7:0]));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (imem_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_loadi)                 state_d = ST_IMM;
        else if (is_load || is_store) state_d = ST_MEM;
        else                          state_d = ST_EXEC;
      end
      ST_IMM:    if (imem_valid) state_d = ST_EXEC;
      ST_MEM:    state_d = ST_EXEC;
      ST_EXEC:   state_d = is_halt ? ST_IDLE : ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    imem_req  = (state_q == ST_FETCH) || (state_q == ST_IMM);
    imem_addr = pc_q;
    en        = (state_q == ST_MEM) || (state_q == ST_EXEC);
    x         = active ? ir_q[11:8] : 4'h0;
    y         = active ? ir_q[7:4]  : 4'h0;
    z         = active ? ir_q[3:0]  : 4'h0;
    I         = active ? imm_q : 16'h0;
    aluc      = (active && is_alu) ? alu_ctrl(op) : ALUC_ADD;
    s2        = 2'b00;
    if (active) begin
      if (is_loadi)     s2 = MUXD_FROM_I;
      else if (is_load) s2 = MUXD_FROM_MEM;
      else              s2 = MUXD_FROM_ALU;
    end
    // a reset landing on the EXEC cycle must not let its write strobes escape
    reg_we    = (state_q == ST_EXEC) && !reset && (is_loadi || is_load || is_alu);
    mem_we    = (state_q == ST_EXEC) && !reset && is_store;
    done      = (state_q == ST_EXEC) && !reset && is_halt;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_spcore_ctrl.sv
// Scoreboard bench for spcore_ctrl: an instruction-level interpreter predicts the
// fetch/write/done event stream, a negedge monitor compares what the DUT emits.
module tb_spcore_ctrl;
  import spcore_ctrl_pkg::*;

  localparam int PC_W     = 8;
  localparam int START_PC = 0;
  localparam int W        = 48;

  logic            clk, reset, start, busy, done, imem_req, imem_valid, P;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data, I;
  logic [3:0]      x, y, z, aluc;
  logic [1:0]      s2;
  logic            reg_we, mem_we, en;
  logic [2:0]      state_dbg;

  spcore_ctrl #(.PC_W(PC_W), .START_PC(START_PC)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_valid(imem_valid), .P(P), .x(x), .y(y), .z(z), .I(I), .aluc(aluc),
    .s2(s2), .reg_we(reg_we), .mem_we(mem_we), .en(en), .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          en_cnt   = 0;
  int          stall_pct = 0;
  int          imm_stall = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] mem [256];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev_fetch(input logic [7:0] a);
    return {4'h1, 36'h0, a};
  endfunction
  function automatic logic [W-1:0] ev_regw(input logic [3:0] rx, ry, rz, ac,
                                           input logic [1:0] sel, input logic e,
                                           input logic [15:0] imm);
    return {4'h2, rx, ry, rz, ac, sel, e, 9'h0, imm};
  endfunction
  function automatic logic [W-1:0] ev_memw(input logic [3:0] rx, ry, rz, input logic e);
    return {4'h3, rx, ry, rz, e, 31'h0};
  endfunction
  function automatic logic [W-1:0] ev_done(input logic b);
    return {4'h4, b, 43'h0};
  endfunction

  // instruction memory responder: random wait states plus a forced stall in IMM
  always @(posedge clk) begin
    #1;
    if (imem_req && state_dbg == 3'(ST_IMM) && imm_stall > 0) begin
      imm_stall--;
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
    end else if (imem_req && $urandom_range(0, 99) >= stall_pct) begin
      imem_valid = 1'b1;
      imem_data  = mem[imem_addr];
    end else begin
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] obs;
    bit           have;
    if (!reset) begin
      have = 1'b0;
      obs  = '0;
      if (en) en_cnt++;
      if (imem_req)
        chk("no_strobe_while_fetching", W'({reg_we, mem_we, done, en}), '0);
      if (reg_we || mem_we || done)
        chk("single_strobe", W'(int'(reg_we) + int'(mem_we) + int'(done)), W'(1));
      if (imem_req && imem_valid) begin
        obs = ev_fetch(imem_addr); have = 1'b1;
      end else if (reg_we) begin
        obs = ev_regw(x, y, z, (s2 == MUXD_FROM_ALU) ? aluc : 4'h0, s2, en,
                      (s2 == MUXD_FROM_I) ? I : 16'h0);
        have = 1'b1;
      end else if (mem_we) begin
        obs = ev_memw(x, y, z, en); have = 1'b1;
      end else if (done) begin
        obs = ev_done(busy); have = 1'b1;
      end
      if (have) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got %h expected none", obs);
        end else begin
          chk("event", obs, exp_q.pop_front());
        end
      end
    end
  end

  // Reference interpreter: walks the program one instruction at a time.
  task automatic model(input bit p, output bit halted, output int exp_en);
    logic [W-1:0] q[$];
    int           pc;
    logic [15:0]  w;
    pc     = START_PC;
    halted = 1'b0;
    exp_en = 0;
    for (int steps = 0; steps < 200 && !halted; steps++) begin
      w = mem[pc];
      q.push_back(ev_fetch(8'(pc)));
      pc = (pc + 1) % 256;
      exp_en++;
      case (w[15:12])
        4'h1: begin
          q.push_back(ev_fetch(8'(pc)));
          q.push_back(ev_regw(w[11:8], w[7:4], w[3:0], 4'h0, MUXD_FROM_I, 1'b1, mem[pc]));
          pc = (pc + 1) % 256;
        end
        4'h2: begin
          q.push_back(ev_regw(w[11:8], w[7:4], w[3:0], 4'h0, MUXD_FROM_MEM, 1'b1, 16'h0));
          exp_en++;
        end
        4'h3: begin
          q.push_back(ev_memw(w[11:8], w[7:4], w[3:0], 1'b1));
          exp_en++;
        end
        4'h4: if (p) pc = (pc + int'($signed(w[7:0])) + 256) % 256;
        4'h7: begin
          q.push_back(ev_done(1'b1));
          halted = 1'b1;
        end
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
          q.push_back(ev_regw(w[11:8], w[7:4], w[3:0], 4'(int'(w[15:12]) - 8),
                              MUXD_FROM_ALU, 1'b1, 16'h0));
        default: ;
      endcase
    end
    if (halted) foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  // driver: start the program, wait for done (bounded), then check drain and en count
  task automatic run_prog(input bit p, input bit junk_start, input int exp_en, output int cycles);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    P      = p;
    en_cnt = 0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      start = junk_start && ($urandom_range(0, 5) == 0);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 4000 cycles");
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("queue_drained", W'(exp_q.size()), '0);
    chk("en_cycles", W'(en_cnt), W'(exp_en));
    chk("idle_after_halt", W'(busy), '0);
    exp_q.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h7000;
  endtask

  task automatic load_prog35();
    clear_mem();
    mem[0] = 16'h1000; mem[1] = 16'h000B; mem[2] = 16'h1100;
    mem[3] = 16'h0016; mem[4] = 16'h8201; mem[5] = 16'h7000;
  endtask

  initial begin
    bit halted;
    int exp_en, cycles;
    reset = 1'b1; start = 1'b0; P = 1'b0;
    imem_valid = 1'b0; imem_data = 16'h0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {busy, done, imem_req, reg_we, mem_we, en, x, y, z, I, aluc, s2, imem_addr},
        {6'b0, 12'h0, 16'h0, 4'h0, 2'b00, 8'(START_PC)});
    @(posedge clk); #1;
    reset = 1'b0;

    // LOADI/LOADI/ADD/HALT with single-cycle fetch: 4+4+3+3 cycles to done
    load_prog35();
    model(1'b0, halted, exp_en);
    run_prog(1'b0, 1'b0, exp_en, cycles);
    chk("prog35_latency", W'(cycles), W'(14));

    // STORE then HALT
    clear_mem();
    mem[0] = 16'h3200;
    model(1'b0, halted, exp_en);
    run_prog(1'b0, 1'b0, exp_en, cycles);
    chk("store_latency", W'(cycles), W'(7));

    // BRP -2 at PC=5, taken: reaches the HALT at 4
    clear_mem();
    mem[0] = 16'h4004; mem[5] = 16'h40FE;
    model(1'b1, halted, exp_en);
    run_prog(1'b1, 1'b0, exp_en, cycles);

    // same BRP not taken: falls through to the HALT at 6
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 16'h0000;
    mem[5] = 16'h40FE;
    model(1'b0, halted, exp_en);
    run_prog(1'b0, 1'b0, exp_en, cycles);

    // three-cycle wait on the LOADI immediate word
    load_prog35();
    imm_stall = 3;
    model(1'b0, halted, exp_en);
    run_prog(1'b0, 1'b0, exp_en, cycles);
    chk("imm_stall_latency", W'(cycles), W'(17));

    // reset while parked in IMM, then rerun
    load_prog35();
    imm_stall = 1000;
    model(1'b0, halted, exp_en);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    halted = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (state_dbg == 3'(ST_IMM)) begin
        halted = 1'b1;
        break;
      end
    end
    chk("reached_imm", W'(halted), W'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    imm_stall = 0;
    @(negedge clk);
    chk("reset_in_imm", {busy, reg_we, imem_addr}, {1'b0, 1'b0, 8'(START_PC)});
    model(1'b0, halted, exp_en);
    run_prog(1'b0, 1'b0, exp_en, cycles);

    // random programs, random wait states, stray start pulses while busy
    for (int n = 0; n < 30; n++) begin
      bit p;
      p = 1'($urandom_range(0, 1));
      do begin
        clear_mem();
        for (int i = 0; i < int'($urandom_range(3, 20)); i++)
          mem[i] = 16'($urandom);
        model(p, halted, exp_en);
      end while (!halted);
      stall_pct = $urandom_range(0, 40);
      run_prog(p, 1'b1, exp_en, cycles);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
